collision_probe: RTL and testbench

COLLISION_PROBE -- requirements
Module: collision_probe

---
 rtl/collision_probe_pkg.sv | 28 ++
 rtl/collision_probe_neighbour.sv | 52 +++++
 rtl/collision_probe.sv | 236 +++++++++++++++++++++++
 tb/tb_collision_probe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_probe_pkg.sv
// Shared tile codes, default map geometry and state/direction encodings
// for the collision probe slice.
package collision_probe_pkg;

  localparam int unsigned MAP_W_DEF = 180;
  localparam int unsigned MAP_H_DEF = 12;

  localparam logic [5:0] EMPTY_CODE_DEF = 6'd0;
  localparam logic [5:0] BRICK_CODE_DEF = 6'd3;
  localparam logic [5:0] OOM_CODE       = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_WRITE,
    S_DONE,
    S_RELOAD
  } state_t;

  // Probe order is the natural enum order: up, down, left, right.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

endpackage

// File: rtl/collision_probe_neighbour.sv
// Neighbour tile coordinate for one direction; falls back to the origin
// when the neighbour lies outside the map.
module tile_neighbour
  import collision_probe_pkg::*;
#(
  parameter int unsigned MAP_W = MAP_W_DEF,
  parameter int unsigned MAP_H = MAP_H_DEF
) (
  input  logic [7:0] xpos,
  input  logic [3:0] ypos,
  input  logic [1:0] dir,
  output logic [7:0] nx,
  output logic [3:0] ny,
  output logic       in_map
);

  logic x_ok;
  logic y_ok;

  assign x_ok = {24'd0, xpos} < MAP_W;
  assign y_ok = {28'd0, ypos} < MAP_H;

  always_comb begin
    nx     = xpos;
    ny     = ypos;
    in_map = 1'b0;
    case (dir_t'(dir))
      DIR_UP: begin
        in_map = x_ok && (({28'd0, ypos} + 32'd1) < MAP_H);
        if (in_map) ny = ypos + 4'd1;
      end
      DIR_DOWN: begin
        in_map = x_ok && y_ok && (ypos != 4'd0);
        if (in_map) ny = ypos - 4'd1;
      end
      DIR_LEFT: begin
        in_map = y_ok && x_ok && (xpos != 8'd0);
        if (in_map) nx = xpos - 8'd1;
      end
      DIR_RIGHT: begin
        in_map = y_ok && (({24'd0, xpos} + 32'd1) < MAP_W);
        if (in_map) nx = xpos + 8'd1;
      end
      default: begin
        nx     = xpos;
        ny     = ypos;
        in_map = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/collision_probe.sv
// Four-way collision probe around a character tile with optional brick
// break above it, plus map reload handshake with the map stage.
module collision_probe
  import collision_probe_pkg::*;
#(
  parameter int unsigned MAP_W      = MAP_W_DEF,
  parameter int unsigned MAP_H      = MAP_H_DEF,
  parameter logic [5:0]  BRICK_CODE = BRICK_CODE_DEF,
  parameter logic [5:0]  EMPTY_CODE = EMPTY_CODE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] char_xpos,
  input  logic [3:0] char_ypos,
  input  logic       break_en,
  input  logic       restart_req,
  input  logic       backuped,
  input  logic [5:0] block,
  input  logic       blocking,
  output logic [7:0] plane_xpos,
  output logic [3:0] plane_ypos,
  output logic       save_block,
  output logic [5:0] write_block,
  output logic       copy_backup,
  output logic       map_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] solid,
  output logic [5:0] blk_up,
  output logic [5:0] blk_down,
  output logic [5:0] blk_left,
  output logic [5:0] blk_right,
  output logic       broke
);

  state_t     state;
  logic [7:0] pos_x;
  logic [3:0] pos_y;
  logic       brk;
  logic [2:0] cnt;
  logic       cur_in;

  dir_t       cur_dir;
  dir_t       nb_dir;
  logic [7:0] nb_xin;
  logic [3:0] nb_yin;
  logic [7:0] nb_x;
  logic [3:0] nb_y;
  logic       nb_in;

  logic       smp_solid;
  logic [5:0] smp_code;
  logic       req_oob;
  logic       wr_go;

  assign cur_dir = dir_t'(cnt[2:1]);

  // The look-ahead direction wraps from RIGHT back to UP on the last probe
  // cycle, which is exactly the address the brick write needs.
  always_comb begin
    nb_dir = DIR_UP;
    nb_xin = pos_x;
    nb_yin = pos_y;
    if (state == S_IDLE) begin
      nb_xin = char_xpos;
      nb_yin = char_ypos;
    end else if (state == S_PROBE) begin
      nb_dir = dir_t'(cnt[2:1] + 2'd1);
    end
  end

  tile_neighbour #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H)
  ) u_neighbour (
    .xpos  (nb_xin),
    .ypos  (nb_yin),
    .dir   (nb_dir),
    .nx    (nb_x),
    .ny    (nb_y),
    .in_map(nb_in)
  );

  always_comb begin
    smp_solid = blocking;
    smp_code  = block;
    if (!cur_in) begin
      if (cur_dir == DIR_UP || cur_dir == DIR_DOWN) begin
        smp_solid = 1'b0;
        smp_code  = EMPTY_CODE;
      end else begin
        smp_solid = 1'b1;
        smp_code  = OOM_CODE;
      end
    end
  end

  assign req_oob = ({24'd0, char_xpos} >= MAP_W) || ({28'd0, char_ypos} >= MAP_H);
  assign wr_go   = brk && (blk_up == BRICK_CODE) && nb_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RELOAD;
      pos_x       <= '0;
      pos_y       <= '0;
      brk         <= 1'b0;
      cnt         <= '0;
      cur_in      <= 1'b0;
      plane_xpos  <= '0;
      plane_ypos  <= '0;
      save_block  <= 1'b0;
      write_block <= '0;
      copy_backup <= 1'b0;
      map_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      solid       <= '0;
      blk_up      <= '0;
      blk_down    <= '0;
      blk_left    <= '0;
      blk_right   <= '0;
      broke       <= 1'b0;
    end else begin
      copy_backup <= 1'b0;
      save_block  <= 1'b0;
      write_block <= '0;
      done        <= 1'b0;
      if (backuped) map_ready <= 1'b1;

      if (restart_req && state != S_RELOAD) begin
        state       <= S_RELOAD;
        copy_backup <= 1'b1;
        map_ready   <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (req && map_ready) begin
              pos_x     <= char_xpos;
              pos_y     <= char_ypos;
              brk       <= break_en;
              cnt       <= '0;
              busy      <= 1'b1;
              err       <= 1'b0;
              broke     <= 1'b0;
              solid     <= '0;
              blk_up    <= '0;
              blk_down  <= '0;
              blk_left  <= '0;
              blk_right <= '0;
              if (req_oob) begin
                state <= S_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                state      <= S_PROBE;
                plane_xpos <= nb_x;
                plane_ypos <= nb_y;
                cur_in     <= nb_in;
              end
            end
          end

          S_PROBE: begin
            cnt <= cnt + 3'd1;
            if (cnt[0]) begin
              case (cur_dir)
                DIR_UP: begin
                  solid[3] <= smp_solid;
                  blk_up   <= smp_code;
                end
                DIR_DOWN: begin
                  solid[2] <= smp_solid;
                  blk_down <= smp_code;
                end
                DIR_LEFT: begin
                  solid[1] <= smp_solid;
                  blk_left <= smp_code;
                end
                default: begin
                  solid[0]  <= smp_solid;
                  blk_right <= smp_code;
                end
              endcase
              if (cnt == 3'd7) begin
                if (wr_go) begin
                  state       <= S_WRITE;
                  plane_xpos  <= nb_x;
                  plane_ypos  <= nb_y;
                  save_block  <= 1'b1;
                  write_block <= EMPTY_CODE;
                  broke       <= 1'b1;
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end else begin
                plane_xpos <= nb_x;
                plane_ypos <= nb_y;
                cur_in     <= nb_in;
              end
            end
          end

          S_WRITE: begin
            state <= S_DONE;
            done  <= 1'b1;
          end

          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          S_RELOAD: begin
            if (backuped) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end

          default: begin
            state <= S_RELOAD;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_probe.sv
// Randomised bench for collision_probe with a map-stage responder and a
// transaction-level reference model checked every cycle.
module tb_collision_probe;

  localparam int W = 180;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [7:0] char_xpos = '0;
  logic [3:0] char_ypos = '0;
  logic       break_en = 1'b0;
  logic       restart_req = 1'b0;
  logic       backuped;
  logic [5:0] block;
  logic       blocking;
  logic [7:0] plane_xpos;
  logic [3:0] plane_ypos;
  logic       save_block;
  logic [5:0] write_block;
  logic       copy_backup;
  logic       map_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] solid;
  logic [5:0] blk_up, blk_down, blk_left, blk_right;
  logic       broke;

  always #5 clk = ~clk;

  collision_probe #(
    .MAP_W(180),
    .MAP_H(12),
    .BRICK_CODE(6'd3),
    .EMPTY_CODE(6'd0)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .char_xpos(char_xpos), .char_ypos(char_ypos),
    .break_en(break_en), .restart_req(restart_req), .backuped(backuped),
    .block(block), .blocking(blocking), .plane_xpos(plane_xpos), .plane_ypos(plane_ypos),
    .save_block(save_block), .write_block(write_block), .copy_backup(copy_backup),
    .map_ready(map_ready), .busy(busy), .done(done), .err(err), .solid(solid),
    .blk_up(blk_up), .blk_down(blk_down), .blk_left(blk_left), .blk_right(blk_right),
    .broke(broke)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Map stage: live map, backup copy, reload delay and tile writes.
  logic [5:0] map [H][W];
  logic [5:0] bak [H][W];
  logic       load = 1'b0;
  int         bk_delay = 4;
  int         pend;

  always_comb begin
    block    = '0;
    blocking = 1'b0;
    if (int'(plane_ypos) < H && int'(plane_xpos) < W) begin
      block    = map[plane_ypos][plane_xpos];
      blocking = map[plane_ypos][plane_xpos] != 6'd0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 6;
      backuped <= 1'b0;
      map      <= bak;
    end else begin
      backuped <= 1'b0;
      if (load) map <= bak;
      if (save_block && int'(plane_ypos) < H && int'(plane_xpos) < W)
        map[plane_ypos][plane_xpos] <= write_block;
      if (copy_backup) pend <= bk_delay;
      else if (pend == 1) begin
        backuped <= 1'b1;
        map      <= bak;
        pend     <= 0;
      end else if (pend > 1) pend <= pend - 1;
    end
  end

  // Reference model: mode 0 idle, 1 transaction (t = cycles since accept), 2 reload.
  bit         chk_on = 1'b0;
  int         m_mode = 2;
  int         m_t, m_len;
  bit         m_cb = 1'b0, m_mr = 1'b0, m_resv = 1'b0, m_wr, m_err;
  int         ax[4], ay[4];
  logic [5:0] m_code[4];
  logic [3:0] m_solid;

  task automatic accept(input int x, input int y, input bit brk);
    int nx, ny;
    bit sb;
    m_resv  = 1'b0;
    m_mode  = 1;
    m_t     = 1;
    m_err   = (x >= W) || (y >= H);
    m_solid = '0;
    m_wr    = 1'b0;
    for (int d = 0; d < 4; d++) m_code[d] = '0;
    if (m_err) m_len = 1;
    else begin
      for (int d = 0; d < 4; d++) begin
        nx = x + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        ny = y + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
        if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
          ax[d] = nx; ay[d] = ny;
          m_code[d] = map[ny][nx];
          sb = map[ny][nx] != 6'd0;
        end else begin
          ax[d] = x; ay[d] = y;
          m_code[d] = (d >= 2) ? 6'h3F : 6'h00;
          sb = (d >= 2);
        end
        m_solid[3-d] = sb;
      end
      m_wr  = brk && (m_code[0] == 6'd3) && (y + 1 < H);
      m_len = m_wr ? 10 : 9;
    end
  endtask

  always @(negedge clk) begin
    bit probing, writing, dn;
    int k;
    if (chk_on) begin
      probing = (m_mode == 1) && !m_err && m_t >= 1 && m_t <= 8;
      writing = (m_mode == 1) && m_wr && m_t == 9;
      dn      = (m_mode == 1) && m_t == m_len;
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("done", 32'(done), 32'(dn));
      chk("save_block", 32'(save_block), 32'(writing));
      chk("copy_backup", 32'(copy_backup), 32'(m_cb));
      chk("map_ready", 32'(map_ready), 32'(m_mr));
      if (probing) begin
        k = (m_t - 1) / 2;
        chk("probe_x", 32'(plane_xpos), ax[k]);
        chk("probe_y", 32'(plane_ypos), ay[k]);
      end
      if (writing) begin
        chk("write_x", 32'(plane_xpos), ax[0]);
        chk("write_y", 32'(plane_ypos), ay[0]);
        chk("write_block", 32'(write_block), 0);
      end
      if (dn || (m_mode == 0 && m_resv)) begin
        chk("err", 32'(err), 32'(m_err));
        chk("broke", 32'(broke), 32'(m_wr));
        chk("solid", 32'(solid), 32'(m_solid));
        chk("blk_up", 32'(blk_up), 32'(m_code[0]));
        chk("blk_down", 32'(blk_down), 32'(m_code[1]));
        chk("blk_left", 32'(blk_left), 32'(m_code[2]));
        chk("blk_right", 32'(blk_right), 32'(m_code[3]));
      end
      if (m_mode != 2 && restart_req) begin
        m_mode = 2; m_cb = 1'b1; m_mr = 1'b0; m_resv = 1'b0;
      end else begin
        m_cb = 1'b0;
        if (m_mode == 0) begin
          if (req && m_mr) accept(int'(char_xpos), int'(char_ypos), break_en);
        end else if (m_mode == 1) begin
          if (m_t == m_len) begin m_mode = 0; m_resv = 1'b1; end
          else m_t++;
        end else if (backuped) m_mode = 0;
      end
      if (backuped) m_mr = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_map();
    load = 1'b1; tick(); load = 1'b0; tick();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (map_ready) break;
      tick();
    end
    chk("map_ready_wait", 32'(map_ready), 1);
  endtask

  task automatic do_req(input int x, input int y, input bit brk, output int lat);
    char_xpos = 8'(x); char_ypos = 4'(y); break_en = brk; req = 1'b1;
    tick();
    req = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (done === 1'b1) begin lat = i; break; end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nd, ns;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) bak[y][x] = 6'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_map_ready", 32'(map_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_solid", 32'(solid), 0);
    chk("rst_plane_x", 32'(plane_xpos), 0);
    chk("rst_copy_backup", 32'(copy_backup), 0);
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    wait_ready();

    // Left neighbour solid only.
    bak[5][9] = 6'd7;
    load_map();
    do_req(10, 5, 1'b0, lat);
    chk("lat_basic", lat, 9);
    chk("solid_basic", 32'(solid), 32'b0010);
    chk("err_basic", 32'(err), 0);
    chk("blk_left_basic", 32'(blk_left), 7);
    tick();

    // Bottom-left corner.
    do_req(0, 0, 1'b0, lat);
    chk("lat_corner", lat, 9);
    chk("solid_corner", 32'(solid), 32'b0010);
    chk("blk_left_corner", 32'(blk_left), 32'h3F);
    chk("blk_down_corner", 32'(blk_down), 0);
    tick();

    // Brick break above.
    bak[4][20] = 6'd3;
    load_map();
    do_req(20, 3, 1'b1, lat);
    chk("lat_break", lat, 10);
    chk("broke_break", 32'(broke), 1);
    chk("blk_up_break", 32'(blk_up), 3);
    tick();
    chk("map_after_break", 32'(map[4][20]), 0);

    // Restart mid-probe.
    bk_delay = 20;
    char_xpos = 8'd30; char_ypos = 4'd6; break_en = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    chk("abort_copy_backup", 32'(copy_backup), 1);
    chk("abort_map_ready", 32'(map_ready), 0);
    nd = 0; ns = 0;
    for (int i = 0; i < 15; i++) begin
      req = (i == 2);
      tick();
      if (done) nd++;
      if (save_block) ns++;
    end
    req = 1'b0;
    chk("abort_no_done", nd, 0);
    chk("abort_no_save", ns, 0);
    wait_ready();
    bk_delay = 4;
    tick();

    // Out-of-range request, then request while busy.
    do_req(180, 2, 1'b0, lat);
    chk("lat_err", lat, 1);
    chk("err_flag", 32'(err), 1);
    chk("solid_err", 32'(solid), 0);
    tick();
    char_xpos = 8'd40; char_ypos = 4'd7; req = 1'b1;
    tick();
    req = 1'b0;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      req = (i == 1);
      if (done) nd++;
      tick();
    end
    req = 1'b0;
    chk("busy_single_done", nd, 1);

    // Random phase over a random map.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int r;
        r = $urandom_range(0, 7);
        bak[y][x] = (r < 4) ? 6'd0 : (r < 6) ? 6'd3 : 6'($urandom_range(1, 62));
      end
    load_map();
    for (int c = 0; c < 2500; c++) begin
      int r;
      req = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      char_xpos = (r == 0) ? 8'd0 : (r == 1) ? 8'd179 : 8'($urandom_range(0, 200));
      r = $urandom_range(0, 9);
      char_ypos = (r == 0) ? 4'd0 : (r == 1) ? 4'd11 : 4'($urandom_range(0, 13));
      break_en = $urandom_range(0, 1) == 1;
      restart_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) bk_delay = $urandom_range(1, 6);
      tick();
    end
    req = 1'b0;
    restart_req = 1'b0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
